serializer_arb: RTL

Round-robin scheduler that shares one `serializer` instance among `N_REQ` requesters. Each requester offers a word and bit count with a valid/ready handshake. The block accepts one request at a time, issues it to the serializer as a single-cycle `data_val_i` pulse, and tracks the serializer's `busy_o` until the word has been shifted out. It sits directly in front of `serializer`: its `ser_*` outputs drive the serializer inputs, and the serializer's `busy_o` drives `ser_busy_i`.

---
 rtl/serializer_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/serializer_arb.sv | 119 +++++++++++
 3 files changed

// File: rtl/serializer_arb_pkg.sv
// Shared types and helpers for the serializer round-robin scheduler.
package serializer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } arb_state_t;

    localparam int unsigned MOD_ILLEGAL_1 = 1;
    localparam int unsigned MOD_ILLEGAL_2 = 2;

    // Bit counts of 1 and 2 cannot be produced by the serializer.
    function automatic logic mod_legal(input int unsigned m);
        return (m != MOD_ILLEGAL_1) && (m != MOD_ILLEGAL_2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/serializer_arb.sv
// Round-robin scheduler sharing one serializer among N_REQ requesters.
module serializer_arb
    import serializer_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 16,
    parameter int MOD_W    = 4,
    parameter int START_TO = 4
) (
    input  logic                          clk_i,
    input  logic                          arst_n_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
    input  logic [N_REQ-1:0][MOD_W-1:0]   req_mod_i,
    input  logic [N_REQ-1:0]              req_val_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic [DATA_W-1:0]             ser_data_o,
    output logic [MOD_W-1:0]              ser_mod_o,
    output logic                          ser_val_o,
    input  logic                          ser_busy_i,
    output logic [N_REQ-1:0]              grant_o,
    output logic                          drop_o,
    output logic                          err_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(START_TO + 1);

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic             any;
    logic             arb_en;
    logic             win_legal;
    logic             issue;
    logic             drop;
    logic             done;
    logic             timeout;

    // Arbitration runs only when idle or when the current word has just finished.
    assign arb_en = (state == IDLE) || ((state == WAIT_DONE) && !ser_busy_i);

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req_val_i),
        .ptr     (ptr),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready_o = gnt;
    assign win_legal   = mod_legal(32'(req_mod_i[gnt_idx]));

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: state_nxt = IDLE;
            ISSUE: state_nxt = WAIT_START;
            WAIT_START: begin
                if (ser_busy_i) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_W'(START_TO - 1)) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        issue = any && win_legal;
        drop  = any && !win_legal;
        if (issue) begin
            state_nxt = ISSUE;
        end
        ptr_nxt = ptr;
        if (any) begin
            ptr_nxt = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            ser_data_o <= '0;
            ser_mod_o  <= '0;
            ser_val_o  <= 1'b0;
            grant_o    <= '0;
            drop_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= (state == WAIT_START) ? cnt + 1'b1 : '0;
            ser_val_o <= issue;
            drop_o    <= drop;
            err_o     <= timeout;
            // A new win in the finishing cycle takes precedence over clearing the grant.
            if (issue) begin
                ser_data_o <= req_data_i[gnt_idx];
                ser_mod_o  <= req_mod_i[gnt_idx];
                grant_o    <= gnt;
            end else if (done || timeout) begin
                grant_o <= '0;
            end
        end
    end

endmodule
